// File: rtl/sort_pkg.sv
// Shared types and helpers for the in-place bubble-sort engine: FSM state
// encoding, wrapped address arithmetic and the swap decision.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CMP,
    WR_A,
    WR_B,
    PASS_END,
    FIN
  } state_t;

  // (base + ofs) mod 2^aw; callers truncate the result to their address width.
  function automatic logic [31:0] wrap_addr(input logic [31:0] base,
                                            input logic [31:0] ofs,
                                            input int unsigned aw);
    logic [31:0] mask;
    mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    return (base + ofs) & mask;
  endfunction

  // Operands are left-justified to 64 bits so one comparator serves every
  // element width, signed or unsigned. Strict compare keeps equal keys in place.
  function automatic logic cmp_swap(input logic [63:0] a,
                                    input logic [63:0] b,
                                    input logic desc,
                                    input logic sgn,
                                    input int unsigned dw);
    logic [63:0] a_j;
    logic [63:0] b_j;
    logic a_gt_b;
    logic a_lt_b;
    a_j = a << (64 - dw);
    b_j = b << (64 - dw);
    if (sgn) begin
      a_gt_b = $signed(a_j) > $signed(b_j);
      a_lt_b = $signed(a_j) < $signed(b_j);
    end else begin
      a_gt_b = a_j > b_j;
      a_lt_b = a_j < b_j;
    end
    return desc ? a_lt_b : a_gt_b;
  endfunction

endpackage

// File: rtl/sort_ram.sv
// Single-port synchronous RAM, read-first, registered 1-cycle read.
// Contents are intentionally not reset.
module sort_ram
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  write_req,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (write_req) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/sort_engine_v2.sv
// In-place bubble sort over a wrapped RAM region with early exit, asc/desc
// and signed/unsigned ordering; the host owns the RAM port whenever idle.
module sort_engine_v2
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  order_valid,
  output logic                  order_busy,
  input  logic [ADDR_WIDTH-1:0] order_start,
  input  logic [LEN_WIDTH-1:0]  order_len,
  input  logic                  order_desc,
  input  logic                  order_signed,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  swap_count,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic                  host_wr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(DEPTH);

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] i_reg;
  logic [ADDR_WIDTH-1:0] limit_reg;
  logic [ADDR_WIDTH-1:0] start_reg;
  logic                  desc_reg;
  logic                  signed_reg;
  logic                  swapped_reg;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic                  busy_reg;
  logic                  done_reg;
  logic [CNT_WIDTH-1:0]  swap_count_reg;

  logic [LEN_WIDTH-1:0]  len_eff;
  logic [ADDR_WIDTH-1:0] limit_init;
  logic [ADDR_WIDTH-1:0] i_plus1;
  logic                  last_cmp;
  logic                  swap_now;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [ADDR_WIDTH-1:0] addr_i1;

  logic [ADDR_WIDTH-1:0] eng_addr;
  logic [DATA_WIDTH-1:0] eng_din;
  logic                  eng_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_dout;

  assign len_eff    = (order_len > DEPTH_L) ? DEPTH_L : order_len;
  assign limit_init = ADDR_WIDTH'(len_eff - LEN_WIDTH'(1));
  assign i_plus1    = i_reg + ADDR_WIDTH'(1);
  assign last_cmp   = (i_plus1 == limit_reg);
  assign addr_i     = ADDR_WIDTH'(wrap_addr(32'(start_reg), 32'(i_reg), ADDR_WIDTH));
  assign addr_i1    = ADDR_WIDTH'(wrap_addr(32'(start_reg), 32'(i_reg) + 32'd1, ADDR_WIDTH));
  // In CMP the second operand is still on the RAM output, not yet in b_reg.
  assign swap_now   = cmp_swap(64'(a_reg), 64'(ram_dout), desc_reg, signed_reg, DATA_WIDTH);

  always_comb begin
    eng_addr = addr_i;
    eng_din  = '0;
    eng_we   = 1'b0;
    case (state_reg)
      RD_B: eng_addr = addr_i1;
      WR_A: begin
        eng_din = b_reg;
        eng_we  = 1'b1;
      end
      WR_B: begin
        eng_addr = addr_i1;
        eng_din  = a_reg;
        eng_we   = 1'b1;
      end
      default: ;
    endcase
  end

  // Host traffic, including writes, is simply not routed while busy.
  assign ram_addr = busy_reg ? eng_addr : host_addr;
  assign ram_din  = busy_reg ? eng_din  : host_wdata;
  assign ram_we   = busy_reg ? eng_we   : host_wr;

  sort_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk      (clk),
    .addr     (ram_addr),
    .din      (ram_din),
    .write_req(ram_we),
    .dout     (ram_dout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      i_reg          <= '0;
      limit_reg      <= '0;
      start_reg      <= '0;
      desc_reg       <= 1'b0;
      signed_reg     <= 1'b0;
      swapped_reg    <= 1'b0;
      a_reg          <= '0;
      b_reg          <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      swap_count_reg <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (order_valid) begin
            busy_reg       <= 1'b1;
            start_reg      <= order_start;
            desc_reg       <= order_desc;
            signed_reg     <= order_signed;
            swap_count_reg <= '0;
            if (len_eff <= LEN_WIDTH'(1)) begin
              state_reg <= FIN;
            end else begin
              i_reg       <= '0;
              limit_reg   <= limit_init;
              swapped_reg <= 1'b0;
              state_reg   <= RD_A;
            end
          end
        end
        RD_A: state_reg <= RD_B;
        RD_B: begin
          a_reg     <= ram_dout;
          state_reg <= CMP;
        end
        CMP: begin
          b_reg <= ram_dout;
          if (swap_now) begin
            state_reg <= WR_A;
          end else if (last_cmp) begin
            state_reg <= PASS_END;
          end else begin
            i_reg     <= i_plus1;
            state_reg <= RD_A;
          end
        end
        WR_A: state_reg <= WR_B;
        WR_B: begin
          if (swap_count_reg != '1) begin
            swap_count_reg <= swap_count_reg + CNT_WIDTH'(1);
          end
          swapped_reg <= 1'b1;
          if (last_cmp) begin
            state_reg <= PASS_END;
          end else begin
            i_reg     <= i_plus1;
            state_reg <= RD_A;
          end
        end
        PASS_END: begin
          // A clean pass, or a final pass of one compare, ends the sort.
          if (!swapped_reg || limit_reg == ADDR_WIDTH'(1)) begin
            state_reg <= FIN;
          end else begin
            limit_reg   <= limit_reg - ADDR_WIDTH'(1);
            i_reg       <= '0;
            swapped_reg <= 1'b0;
            state_reg   <= RD_A;
          end
        end
        FIN: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign order_busy = busy_reg;
  assign done       = done_reg;
  assign swap_count = swap_count_reg;
  assign host_rdata = ram_dout;

endmodule
